// File: rtl/tt_um_result_buffer.sv
// Ping-pong result buffer: captures, requantizes and frames one result per row,
// then drains each frame as a valid/ready byte stream. Optional ReLU via RESULT_BUFFER_RELU_EN.
module tt_um_result_buffer #(
    parameter int OUT_LEN = 7,
    parameter int BIT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [2:0]       in_row,
    input  logic [BIT_W-1:0] in_data,
    input  logic [2:0]       shift,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [BIT_W-1:0] out_data,
    output logic             out_last,
    output logic             overflow,
    output logic             seq_err
);

    localparam logic [1:0] EMPTY    = 2'd0;
    localparam logic [1:0] FILLING  = 2'd1;
    localparam logic [1:0] FULL     = 2'd2;
    localparam logic [1:0] DRAINING = 2'd3;

    localparam logic [2:0] LAST_ROW = 3'(OUT_LEN - 1);
    localparam logic signed [BIT_W:0] SAT_MAX = (BIT_W+1)'((1 << (BIT_W - 1)) - 1);
    localparam logic signed [BIT_W:0] SAT_MIN = (BIT_W+1)'(-(1 << (BIT_W - 1)));

    logic [1:0]       bank_state [2];
    logic [BIT_W-1:0] mem [2][OUT_LEN];
    logic             fill_bank;
    logic             drain_bank;
    logic [2:0]       fill_ptr;
    logic [2:0]       drain_ptr;
    logic [2:0]       shift_q;
    logic             dropping;
    logic             overflow_q;
    logic             seq_err_q;

    logic [1:0]              fill_state;
    logic [1:0]              drain_state;
    logic                    row_oob;
    logic                    fill_busy;
    logic                    start_frame;
    logic                    next_row;
    logic                    write_en;
    logic                    xfer;
    logic [2:0]              eff_shift;
    logic signed [BIT_W:0]   ext;
    logic signed [BIT_W:0]   round_add;
    logic signed [BIT_W:0]   rounded;
    logic signed [BIT_W:0]   shifted;
    logic [BIT_W-1:0]        sat;
    logic [BIT_W-1:0]        quant;

    // Row 0 uses the live shift input; later rows reuse the value latched with row 0.
    always_comb begin
        eff_shift = (in_row == 3'd0) ? shift : shift_q;
        ext       = {in_data[BIT_W-1], in_data};
        round_add = '0;
        if (eff_shift != 3'd0)
            round_add = (BIT_W+1)'(1) << (eff_shift - 3'd1);
        rounded = ext + round_add;
        shifted = rounded >>> eff_shift;
        if (shifted > SAT_MAX)
            sat = SAT_MAX[BIT_W-1:0];
        else if (shifted < SAT_MIN)
            sat = SAT_MIN[BIT_W-1:0];
        else
            sat = shifted[BIT_W-1:0];
`ifdef RESULT_BUFFER_RELU_EN
        quant = sat[BIT_W-1] ? '0 : sat;
`else
        quant = sat;
`endif
    end

    always_comb begin
        fill_state  = bank_state[fill_bank];
        drain_state = bank_state[drain_bank];
        row_oob     = {1'b0, in_row} >= 4'(OUT_LEN);
        fill_busy   = (fill_state == FULL) || (fill_state == DRAINING);
        start_frame = in_valid && !row_oob && (in_row == 3'd0) && !fill_busy;
        next_row    = in_valid && !row_oob && (in_row != 3'd0) && !dropping &&
                      (fill_state == FILLING) && (in_row == fill_ptr);
        write_en    = start_frame || next_row;
        out_valid   = (drain_state == FULL) || (drain_state == DRAINING);
        xfer        = out_valid && out_ready;
        out_data    = out_valid ? mem[drain_bank][drain_ptr] : '0;
        out_last    = out_valid && (drain_ptr == LAST_ROW);
    end

    // Fill and drain only ever touch a bank in disjoint states, so one block can own both.
    always_ff @(posedge clk) begin
        if (rst) begin
            bank_state[0] <= EMPTY;
            bank_state[1] <= EMPTY;
            fill_bank     <= 1'b0;
            drain_bank    <= 1'b0;
            fill_ptr      <= 3'd0;
            drain_ptr     <= 3'd0;
            shift_q       <= 3'd0;
            dropping      <= 1'b0;
            overflow_q    <= 1'b0;
            seq_err_q     <= 1'b0;
        end else begin
            if (in_valid) begin
                if (start_frame) begin
                    if (fill_state == FILLING)
                        seq_err_q <= 1'b1;
                    dropping              <= 1'b0;
                    bank_state[fill_bank] <= FILLING;
                    fill_ptr              <= 3'd1;
                    shift_q               <= shift;
                end else if (next_row) begin
                    if (in_row == LAST_ROW) begin
                        bank_state[fill_bank] <= FULL;
                        fill_bank             <= ~fill_bank;
                        fill_ptr              <= 3'd0;
                    end else begin
                        fill_ptr <= fill_ptr + 3'd1;
                    end
                end else if (!row_oob && (in_row == 3'd0)) begin
                    overflow_q <= 1'b1;
                    dropping   <= 1'b1;
                end else if (row_oob || !dropping) begin
                    seq_err_q <= 1'b1;
                    if (fill_state == FILLING) begin
                        bank_state[fill_bank] <= EMPTY;
                        fill_ptr              <= 3'd0;
                    end
                end
            end

            if (xfer && (drain_ptr == LAST_ROW)) begin
                bank_state[drain_bank] <= EMPTY;
                drain_bank             <= ~drain_bank;
                drain_ptr              <= 3'd0;
            end else begin
                if (xfer)
                    drain_ptr <= drain_ptr + 3'd1;
                if (drain_state == FULL)
                    bank_state[drain_bank] <= DRAINING;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (write_en)
            mem[fill_bank][in_row] <= quant;
    end

    assign overflow = overflow_q;
    assign seq_err  = seq_err_q;

endmodule

// File: tb/tb_tt_um_result_buffer.sv
// Self-checking bench for tt_um_result_buffer: table-driven frames, hand-written
// corner sequences, and a randomized run against a frame-level reference model.
module tb_tt_um_result_buffer;

    typedef logic [0:6][7:0] frame_t;
    typedef struct packed {
        logic [2:0] s;
        frame_t     din;
        frame_t     dout;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [2:0] in_row;
    logic [7:0] in_data;
    logic [2:0] shift;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_last;
    logic       overflow;
    logic       seq_err;

    int checks = 0;
    int errors = 0;

    vec_t   vecs [4];
    frame_t fa, fb, fc;

    frame_t mFrames [$];
    frame_t mPart;
    int     mDptr, mPptr, mShift;
    bit     mFilling, mDrop, mOvf, mSeq;

    always #5 clk = ~clk;

    tt_um_result_buffer #(.OUT_LEN(7), .BIT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_row    (in_row),
        .in_data   (in_data),
        .shift     (shift),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .overflow  (overflow),
        .seq_err   (seq_err)
    );

    function automatic logic [7:0] b(input int v);
        return v[7:0];
    endfunction

    // Floor-division form of the rounding shift, then saturation (and optional ReLU).
    function automatic logic [7:0] refQuant(input int x, input int s);
        int d;
        int v;
        int q;
        d = 1 << s;
        v = x + ((s > 0) ? d / 2 : 0);
        q = (v >= 0) ? v / d : -((-v + d - 1) / d);
        if (q > 127) q = 127;
        if (q < -128) q = -128;
`ifdef RESULT_BUFFER_RELU_EN
        if (q < 0) q = 0;
`endif
        return b(q);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [2:0] r, input logic [7:0] d, input logic [2:0] s);
        in_valid = v;
        in_row   = r;
        in_data  = d;
        shift    = s;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic doReset();
        rst = 1'b1;
        applyStimulus(1'b0, 3'd0, 8'd0, 3'd0);
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Only row 0 carries the intended shift; later rows carry junk to prove it is latched.
    task automatic sendFrame(input frame_t d, input logic [2:0] s);
        for (int r = 0; r < 7; r++) begin
            applyStimulus(1'b1, 3'(r), d[r], (r == 0) ? s : 3'($urandom_range(0, 7)));
            tick();
        end
        applyStimulus(1'b0, 3'd0, 8'd0, 3'd0);
    endtask

    task automatic drainFrame(input string name, input frame_t e);
        for (int i = 0; i < 7; i++) begin
            checkOutput({name, "_valid"}, out_valid, 1);
            checkOutput({name, "_data"}, out_data, e[i]);
            checkOutput({name, "_last"}, out_last, (i == 6) ? 1 : 0);
            tick();
        end
    endtask

    task automatic modelStep(input bit rv, input int row, input int sx, input int sh, input bit rdy);
        int oldSize;
        oldSize = mFrames.size();
        if (oldSize > 0 && rdy) begin
            mDptr++;
            if (mDptr == 7) begin
                void'(mFrames.pop_front());
                mDptr = 0;
            end
        end
        if (!rv) return;
        if (row >= 7) begin
            mSeq = 1;
            mFilling = 0;
            mPptr = 0;
        end else if (row == 0) begin
            if (oldSize == 2) begin
                mOvf = 1;
                mDrop = 1;
            end else begin
                if (mFilling) mSeq = 1;
                mDrop = 0;
                mFilling = 1;
                mShift = sh;
                mPart = '0;
                mPart[0] = refQuant(sx, sh);
                mPptr = 1;
            end
        end else if (mDrop) begin
        end else if (mFilling && row == mPptr) begin
            mPart[row] = refQuant(sx, mShift);
            mPptr++;
            if (mPptr == 7) begin
                mFrames.push_back(mPart);
                mFilling = 0;
                mPptr = 0;
            end
        end else begin
            mSeq = 1;
            mFilling = 0;
            mPptr = 0;
        end
    endtask

    initial begin
        int idx;
        int nextRow;
        bit rv, rdy;
        int row, sh;
        logic [7:0] d;

        vecs[0].s    = 3'd0;
        vecs[0].din  = {b(1), b(2), b(3), b(4), b(5), b(6), b(7)};
        vecs[0].dout = {b(1), b(2), b(3), b(4), b(5), b(6), b(7)};
        vecs[1].s    = 3'd2;
        vecs[1].din  = {b(5), b(6), b(-6), b(127), b(-128), b(2), b(-2)};
        vecs[2].s    = 3'd1;
        vecs[2].din  = {b(3), b(-3), b(-1), b(1), b(127), b(-128), b(0)};
        vecs[3].s    = 3'd7;
        vecs[3].din  = {b(127), b(-128), b(64), b(63), b(-64), b(-65), b(-1)};
`ifdef RESULT_BUFFER_RELU_EN
        vecs[1].dout = {b(1), b(2), b(0), b(32), b(0), b(1), b(0)};
        vecs[2].dout = {b(2), b(0), b(0), b(1), b(64), b(0), b(0)};
        vecs[3].dout = {b(1), b(0), b(1), b(0), b(0), b(0), b(0)};
`else
        vecs[1].dout = {b(1), b(2), b(-1), b(32), b(-32), b(1), b(0)};
        vecs[2].dout = {b(2), b(-1), b(0), b(1), b(64), b(-64), b(0)};
        vecs[3].dout = {b(1), b(-1), b(1), b(0), b(0), b(-1), b(0)};
`endif

        out_ready = 1'b0;
        doReset();
        checkOutput("rst_valid", out_valid, 0);
        checkOutput("rst_data", out_data, 0);
        checkOutput("rst_last", out_last, 0);
        checkOutput("rst_ovf", overflow, 0);
        checkOutput("rst_seq", seq_err, 0);

        // Table frames: latency, ordering, out_last and requant arithmetic.
        out_ready = 1'b1;
        for (int t = 0; t < 4; t++) begin
            for (int r = 0; r < 7; r++) begin
                applyStimulus(1'b1, 3'(r), vecs[t].din[r], (r == 0) ? vecs[t].s : 3'($urandom_range(0, 7)));
                if (r == 6) checkOutput("tbl_early_valid", out_valid, 0);
                tick();
            end
            applyStimulus(1'b0, 3'd0, 8'd0, 3'd0);
            drainFrame("tbl", vecs[t].dout);
            checkOutput("tbl_idle", out_valid, 0);
        end
        checkOutput("tbl_ovf", overflow, 0);
        checkOutput("tbl_seq", seq_err, 0);

        fa = {b(10), b(11), b(12), b(13), b(14), b(15), b(16)};
        fb = {b(20), b(21), b(22), b(23), b(24), b(25), b(26)};
        fc = {b(30), b(31), b(32), b(33), b(34), b(35), b(36)};

        // Out-of-order row discards the partial frame.
        doReset();
        out_ready = 1'b1;
        applyStimulus(1'b1, 3'd0, 8'd1, 3'd0); tick();
        applyStimulus(1'b1, 3'd1, 8'd2, 3'd0); tick();
        applyStimulus(1'b1, 3'd3, 8'd3, 3'd0); tick();
        applyStimulus(1'b0, 3'd0, 8'd0, 3'd0);
        checkOutput("seq_flag", seq_err, 1);
        for (int i = 0; i < 8; i++) begin
            checkOutput("seq_quiet", out_valid, 0);
            tick();
        end
        sendFrame(fa, 3'd0);
        drainFrame("seq_clean", fa);
        checkOutput("seq_ovf", overflow, 0);

        // Alternating ready: each byte shown until taken, none skipped.
        doReset();
        out_ready = 1'b0;
        sendFrame(fb, 3'd0);
        idx = 0;
        for (int c = 0; c < 20 && idx < 7; c++) begin
            out_ready = (c % 2 == 0);
            checkOutput("tog_valid", out_valid, 1);
            checkOutput("tog_data", out_data, fb[idx]);
            checkOutput("tog_last", out_last, (idx == 6) ? 1 : 0);
            tick();
            if (out_ready) idx++;
        end
        checkOutput("tog_count", idx, 7);
        checkOutput("tog_idle", out_valid, 0);

        // Three frames with the consumer stalled: third is dropped, two drain seamlessly.
        doReset();
        out_ready = 1'b0;
        sendFrame(fa, 3'd0);
        sendFrame(fb, 3'd0);
        sendFrame(fc, 3'd0);
        checkOutput("ovf_flag", overflow, 1);
        checkOutput("ovf_seq", seq_err, 0);
        for (int i = 0; i < 3; i++) begin
            checkOutput("ovf_hold_valid", out_valid, 1);
            checkOutput("ovf_hold_data", out_data, fa[0]);
            tick();
        end
        out_ready = 1'b1;
        drainFrame("ovf_f1", fa);
        drainFrame("ovf_f2", fb);
        checkOutput("ovf_idle", out_valid, 0);

        // Reset mid-drain clears stickies and buffered data.
        applyStimulus(1'b1, 3'd7, 8'd0, 3'd0); tick();
        applyStimulus(1'b0, 3'd0, 8'd0, 3'd0);
        checkOutput("oob_seq", seq_err, 1);
        out_ready = 1'b0;
        sendFrame(fb, 3'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checkOutput("mid_data", out_data, fb[i]);
            tick();
        end
        rst = 1'b1;
        tick();
        checkOutput("mid_rst_valid", out_valid, 0);
        checkOutput("mid_rst_ovf", overflow, 0);
        checkOutput("mid_rst_seq", seq_err, 0);
        rst = 1'b0;
        tick();
        checkOutput("mid_rst_after", out_valid, 0);
        sendFrame(fc, 3'd0);
        drainFrame("mid_fresh", fc);

        // Randomized traffic against the frame-level model.
        doReset();
        mFrames.delete();
        mDptr = 0; mPptr = 0; mShift = 0;
        mFilling = 0; mDrop = 0; mOvf = 0; mSeq = 0;
        nextRow = 0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            rv  = ($urandom_range(0, 3) != 0);
            row = nextRow;
            if ($urandom_range(0, 29) == 0) row = $urandom_range(0, 7);
            d   = 8'($urandom);
            sh  = $urandom_range(0, 7);
            rdy = ($urandom_range(0, 2) == 0);
            applyStimulus(rv, 3'(row), d, 3'(sh));
            out_ready = rdy;
            checkOutput("rnd_valid", out_valid, (mFrames.size() > 0) ? 1 : 0);
            if (mFrames.size() > 0) begin
                checkOutput("rnd_data", out_data, mFrames[0][mDptr]);
                checkOutput("rnd_last", out_last, (mDptr == 6) ? 1 : 0);
            end
            checkOutput("rnd_ovf", overflow, mOvf);
            checkOutput("rnd_seq", seq_err, mSeq);
            tick();
            modelStep(rv, row, int'($signed(d)), sh, rdy);
            if (rv) nextRow = (row >= 6) ? 0 : row + 1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
